// File: rtl/alu_core.sv
// alu_core: single-issue ALU. Most ops give a registered result one cycle
// after acceptance; MUL runs a fixed-latency shift-add over DATA_WIDTH cycles
// and holds ALU_RDY low until its last iteration.
module alu_core #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  ACT,
   input  logic [3:0]            OP,
   input  logic [1:0]            MOVI,
   input  logic [DATA_WIDTH-1:0] REG_A,
   input  logic [DATA_WIDTH-1:0] REG_B,
   input  logic [DATA_WIDTH-1:0] MEM,
   input  logic [DATA_WIDTH-1:0] IMM,
   output logic                  ALU_RDY,
   output logic [DATA_WIDTH-1:0] EX_ALU,
   output logic                  EX_ALU_VLD
);

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [3:0] OP_MUL = 4'd2;

   typedef enum logic {S_IDLE, S_MUL} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [CNT_W-1:0]      r_cnt;
   logic [DATA_WIDTH-1:0] r_acc;
   logic [DATA_WIDTH-1:0] r_mcand;
   logic [DATA_WIDTH-1:0] r_mplier;
   logic [DATA_WIDTH-1:0] r_res;
   logic                  r_vld;

   logic [DATA_WIDTH-1:0] w_b;
   logic [DATA_WIDTH-1:0] w_alu;
   logic [DATA_WIDTH-1:0] w_sum;
   logic                  w_rdy;
   logic                  w_accept;
   logic                  w_mul_start;
   logic                  w_mul_done;
   logic                  w_cnt_last;

   // Operand-B source select; only consumed in the acceptance cycle
   always_comb begin
      w_b = '0;
      case (MOVI)
         2'd0:    w_b = REG_B;
         2'd1:    w_b = MEM;
         2'd2:    w_b = IMM;
         default: w_b = '0;
      endcase
   end

   // Single-cycle op results (MUL handled by the iterative datapath)
   always_comb begin
      w_alu = '0;
      case (OP)
         4'd0:    w_alu = REG_A + w_b;
         4'd1:    w_alu = REG_A - w_b;
         4'd3:    w_alu = {REG_A[DATA_WIDTH-2:0], 1'b0};
         4'd4:    w_alu = {1'b0, REG_A[DATA_WIDTH-1:1]};
         4'd5:    w_alu = {REG_A[DATA_WIDTH-2:0], REG_A[DATA_WIDTH-1]};
         4'd6:    w_alu = {REG_A[0], REG_A[DATA_WIDTH-1:1]};
         4'd7:    w_alu = ~REG_A;
         4'd8:    w_alu = REG_A & w_b;
         4'd9:    w_alu = REG_A | w_b;
         4'd10:   w_alu = REG_A ^ w_b;
         4'd11:   w_alu = ~(REG_A & w_b);
         4'd12:   w_alu = ~(REG_A | w_b);
         4'd13:   w_alu = ~(REG_A ^ w_b);
         4'd14:   w_alu = REG_A + DATA_WIDTH'(1);
         4'd15:   w_alu = REG_A - DATA_WIDTH'(1);
         default: w_alu = '0;
      endcase
   end

   // Bit 0 of the multiplier is consumed at acceptance, so the MUL state only
   // needs counter values 1..DATA_WIDTH-1 to finish in DATA_WIDTH cycles
   assign w_sum      = r_acc + (r_mplier[0] ? r_mcand : '0);
   assign w_cnt_last = (r_cnt == CNT_W'(DATA_WIDTH - 1));

   // FSM state register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next state and handshake decode
   always_comb begin
      w_state_nxt = r_state;
      w_rdy       = 1'b0;
      w_accept    = 1'b0;
      w_mul_start = 1'b0;
      w_mul_done  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_rdy = 1'b1;
            if (ACT) begin
               w_accept = 1'b1;
               if (OP == OP_MUL) begin
                  w_mul_start = 1'b1;
                  w_state_nxt = S_MUL;
               end
            end
         end
         S_MUL: begin
            if (w_cnt_last) begin
               w_mul_done  = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Result register, valid strobe and shift-add multiplier datapath
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_res    <= '0;
         r_vld    <= 1'b0;
      end else begin
         r_vld <= 1'b0;
         if (w_accept && !w_mul_start) begin
            r_res <= w_alu;
            r_vld <= 1'b1;
         end
         if (w_mul_start) begin
            r_acc    <= w_b[0] ? REG_A : '0;
            r_mcand  <= {REG_A[DATA_WIDTH-2:0], 1'b0};
            r_mplier <= {1'b0, w_b[DATA_WIDTH-1:1]};
            r_cnt    <= CNT_W'(1);
         end else if (r_state == S_MUL) begin
            if (w_mul_done) begin
               r_res <= w_sum;
               r_vld <= 1'b1;
               r_cnt <= '0;
            end else begin
               r_acc    <= w_sum;
               r_mcand  <= {r_mcand[DATA_WIDTH-2:0], 1'b0};
               r_mplier <= {1'b0, r_mplier[DATA_WIDTH-1:1]};
               r_cnt    <= r_cnt + CNT_W'(1);
            end
         end
      end
   end

   assign ALU_RDY    = w_rdy;
   assign EX_ALU     = r_res;
   assign EX_ALU_VLD = r_vld;

endmodule

// File: tb/tb_alu_core.sv
// Directed bench for alu_core: reset, single ops, MUL latency, back-to-back,
// input stalling, reset abort and an OP x MOVI sweep.
module tb_alu_core;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       ACT = 1'b0;
   logic [3:0] OP = '0;
   logic [1:0] MOVI = '0;
   logic [7:0] REG_A = '0, REG_B = '0, MEM = '0, IMM = '0;
   logic       ALU_RDY;
   logic [7:0] EX_ALU;
   logic       EX_ALU_VLD;

   int checks = 0;
   int failures = 0;

   alu_core #(.DATA_WIDTH(8)) dut (
      .CLK(CLK), .RST(RST), .ACT(ACT), .OP(OP), .MOVI(MOVI),
      .REG_A(REG_A), .REG_B(REG_B), .MEM(MEM), .IMM(IMM),
      .ALU_RDY(ALU_RDY), .EX_ALU(EX_ALU), .EX_ALU_VLD(EX_ALU_VLD)
   );

   always #5 CLK = ~CLK;

   function automatic logic [7:0] ref_alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = 16'(a) * 16'(b);
      case (op)
         4'd0:  return a + b;
         4'd1:  return a - b;
         4'd2:  return p[7:0];
         4'd3:  return {a[6:0], 1'b0};
         4'd4:  return {1'b0, a[7:1]};
         4'd5:  return {a[6:0], a[7]};
         4'd6:  return {a[0], a[7:1]};
         4'd7:  return ~a;
         4'd8:  return a & b;
         4'd9:  return a | b;
         4'd10: return a ^ b;
         4'd11: return ~(a & b);
         4'd12: return ~(a | b);
         4'd13: return ~(a ^ b);
         4'd14: return a + 8'd1;
         default: return a - 8'd1;
      endcase
   endfunction

   task automatic tick();
      @(posedge CLK); #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [1:0] movi, input logic [7:0] a,
                        input logic [7:0] rb, input logic [7:0] m, input logic [7:0] im);
      OP = op; MOVI = movi; REG_A = a; REG_B = rb; MEM = m; IMM = im; ACT = 1'b1;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (2) tick();
      checks++;
      if (ALU_RDY !== 1'b1 || EX_ALU !== 8'h00 || EX_ALU_VLD !== 1'b0) begin
         failures++;
         $display("FAIL reset: rdy=%b ex=%h vld=%b want rdy=1 ex=00 vld=0", ALU_RDY, EX_ALU, EX_ALU_VLD);
      end
      RST = 1'b0;
      tick();
      checks++;
      if (ALU_RDY !== 1'b1 || EX_ALU_VLD !== 1'b0) begin
         failures++;
         $display("FAIL reset_release: rdy=%b vld=%b want rdy=1 vld=0", ALU_RDY, EX_ALU_VLD);
      end
   endtask

   task automatic test_add();
      issue(4'd0, 2'd0, 8'hF0, 8'h20, 8'h00, 8'h00);
      checks++;
      if (ALU_RDY !== 1'b1) begin
         failures++; $display("FAIL add_rdy_pre: rdy=%b want 1", ALU_RDY);
      end
      tick();
      ACT = 1'b0;
      checks++;
      if (EX_ALU_VLD !== 1'b1 || EX_ALU !== 8'h10 || ALU_RDY !== 1'b1) begin
         failures++;
         $display("FAIL add: vld=%b ex=%h rdy=%b want vld=1 ex=10 rdy=1", EX_ALU_VLD, EX_ALU, ALU_RDY);
      end
      tick();
      checks++;
      if (EX_ALU_VLD !== 1'b0 || EX_ALU !== 8'h10) begin
         failures++;
         $display("FAIL add_hold: vld=%b ex=%h want vld=0 ex=10", EX_ALU_VLD, EX_ALU);
      end
   endtask

   // Garbage on the inputs while ACT=0 must leave the held result alone
   task automatic test_idle_x();
      OP = 'x; MOVI = 'x; REG_A = 'x; REG_B = 'x; MEM = 'x; IMM = 'x; ACT = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (EX_ALU_VLD !== 1'b0 || EX_ALU !== 8'h10 || ALU_RDY !== 1'b1) begin
            failures++;
            $display("FAIL idle_x cyc%0d: vld=%b ex=%h rdy=%b want vld=0 ex=10 rdy=1", k, EX_ALU_VLD, EX_ALU, ALU_RDY);
         end
      end
   endtask

   task automatic test_mul();
      issue(4'd2, 2'd2, 8'd13, 8'h00, 8'h00, 8'd11);
      tick();
      ACT = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         checks++;
         if (ALU_RDY !== 1'b0 || EX_ALU_VLD !== 1'b0) begin
            failures++;
            $display("FAIL mul_busy t+%0d: rdy=%b vld=%b want rdy=0 vld=0", k, ALU_RDY, EX_ALU_VLD);
         end
         tick();
      end
      checks++;
      if (EX_ALU_VLD !== 1'b1 || EX_ALU !== 8'h8F || ALU_RDY !== 1'b1) begin
         failures++;
         $display("FAIL mul_done: vld=%b ex=%h rdy=%b want vld=1 ex=8f rdy=1", EX_ALU_VLD, EX_ALU, ALU_RDY);
      end
      tick();
      checks++;
      if (EX_ALU_VLD !== 1'b0) begin
         failures++; $display("FAIL mul_single_pulse: vld=%b want 0", EX_ALU_VLD);
      end
   endtask

   task automatic test_back_to_back();
      issue(4'd10, 2'd1, 8'hAA, 8'h00, 8'hFF, 8'h00);
      tick();
      checks++;
      if (EX_ALU_VLD !== 1'b1 || EX_ALU !== 8'h55) begin
         failures++; $display("FAIL b2b_xor: vld=%b ex=%h want vld=1 ex=55", EX_ALU_VLD, EX_ALU);
      end
      issue(4'd6, 2'd0, 8'h01, 8'h00, 8'h00, 8'h00);
      tick();
      ACT = 1'b0;
      checks++;
      if (EX_ALU_VLD !== 1'b1 || EX_ALU !== 8'h80) begin
         failures++; $display("FAIL b2b_ror: vld=%b ex=%h want vld=1 ex=80", EX_ALU_VLD, EX_ALU);
      end
      tick();
      checks++;
      if (EX_ALU_VLD !== 1'b0) begin
         failures++; $display("FAIL b2b_end: vld=%b want 0", EX_ALU_VLD);
      end
   endtask

   // ADD held on ACT through a MUL: accepted only in the MUL result cycle
   task automatic test_act_held();
      int pulses = 0;
      int cyc1 = -1, cyc2 = -1;
      logic [7:0] v1 = '0, v2 = '0;
      logic drop_next = 1'b0;
      issue(4'd2, 2'd0, 8'd3, 8'd5, 8'h00, 8'h00);
      tick();
      issue(4'd0, 2'd0, 8'd1, 8'd2, 8'h00, 8'h00);
      for (int c = 1; c <= 14; c++) begin
         if (EX_ALU_VLD === 1'b1) begin
            pulses++;
            if (pulses == 1) begin cyc1 = c; v1 = EX_ALU; end
            if (pulses == 2) begin cyc2 = c; v2 = EX_ALU; end
         end
         if (drop_next) ACT = 1'b0;
         if (ACT && ALU_RDY) drop_next = 1'b1;
         tick();
      end
      ACT = 1'b0;
      checks++;
      if (pulses != 2) begin
         failures++; $display("FAIL held_pulses: got %0d want 2", pulses);
      end
      checks++;
      if (cyc1 != 8 || v1 !== 8'd15) begin
         failures++; $display("FAIL held_mul: cyc=%0d ex=%h want cyc=8 ex=0f", cyc1, v1);
      end
      checks++;
      if (cyc2 != 9 || v2 !== 8'd3) begin
         failures++; $display("FAIL held_add: cyc=%0d ex=%h want cyc=9 ex=03", cyc2, v2);
      end
   endtask

   task automatic test_rst_mid_mul();
      int pulses = 0;
      issue(4'd2, 2'd2, 8'd13, 8'h00, 8'h00, 8'd11);
      tick();
      ACT = 1'b0;
      repeat (3) tick();
      RST = 1'b1;
      #1;
      checks++;
      if (ALU_RDY !== 1'b1 || EX_ALU !== 8'h00 || EX_ALU_VLD !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_mul: rdy=%b ex=%h vld=%b want rdy=1 ex=00 vld=0", ALU_RDY, EX_ALU, EX_ALU_VLD);
      end
      #1 RST = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (EX_ALU_VLD === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0 || EX_ALU !== 8'h00 || ALU_RDY !== 1'b1) begin
         failures++;
         $display("FAIL rst_after: pulses=%0d ex=%h rdy=%b want pulses=0 ex=00 rdy=1", pulses, EX_ALU, ALU_RDY);
      end
   endtask

   task automatic run_op(input string name, input logic [3:0] op, input logic [1:0] movi,
                         input logic [7:0] a, input logic [7:0] rb, input logic [7:0] m,
                         input logic [7:0] im, input logic [7:0] exp);
      int lat = 1;
      int exp_lat;
      exp_lat = (op == 4'd2) ? 8 : 1;
      issue(op, movi, a, rb, m, im);
      tick();
      ACT = 1'b0;
      while (EX_ALU_VLD !== 1'b1 && lat < 12) begin
         tick();
         lat++;
      end
      checks++;
      if (EX_ALU_VLD !== 1'b1 || EX_ALU !== exp || lat != exp_lat) begin
         failures++;
         $display("FAIL %s op=%0d movi=%0d: ex=%h lat=%0d vld=%b want ex=%h lat=%0d",
                  name, op, movi, EX_ALU, lat, EX_ALU_VLD, exp, exp_lat);
      end
   endtask

   task automatic test_boundary();
      run_op("sub_wrap", 4'd1,  2'd2, 8'h00, 8'h00, 8'h00, 8'h01, 8'hFF);
      run_op("dec_wrap", 4'd15, 2'd2, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF);
      run_op("inc_wrap", 4'd14, 2'd2, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);
      run_op("shr_81",   4'd4,  2'd2, 8'h81, 8'h00, 8'h00, 8'h00, 8'h40);
      run_op("mul_by1",  4'd2,  2'd2, 8'hFF, 8'h00, 8'h00, 8'h01, 8'hFF);
      run_op("mul_zero", 4'd2,  2'd3, 8'hFF, 8'h12, 8'h34, 8'h56, 8'h00);
      run_op("add_zero", 4'd0,  2'd3, 8'h5A, 8'h12, 8'h34, 8'h56, 8'h5A);
   endtask

   task automatic test_sweep();
      logic [7:0] a, rb, m, im, b;
      a = 8'hB5; rb = 8'h3C; m = 8'hF0; im = 8'h07;
      for (int o = 0; o < 16; o++) begin
         for (int s = 0; s < 4; s++) begin
            case (s)
               0: b = rb;
               1: b = m;
               2: b = im;
               default: b = 8'h00;
            endcase
            run_op("sweep", 4'(o), 2'(s), a, rb, m, im, ref_alu(4'(o), a, b));
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_add();
      test_idle_x();
      test_mul();
      test_back_to_back();
      test_act_held();
      test_rst_mid_mul();
      test_boundary();
      test_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
